tag_pixel_writer: RTL and testbench
===================================

Name: tag_pixel_writer

Overview:
- Encoder side of the 8-bit tagged frame-buffer pixel format.
- Accepts the camera RGB565 stream plus per-pixel threshold and draw flags and a crosshair position.
- Decimates the stream to the frame-buffer resolution, packs each kept pixel into the 8-bit tagged format and writes it into the frame-buffer BRAM.
- Also owns a sequential full-buffer clear sweep.

Parameters:
- IN_WIDTH, 320, active camera pixels per line.
- IN_HEIGHT, 240, active camera lines per frame.
- SCALE_SHIFT, 1, decimation shift. Buffer is (IN_WIDTH>>SCALE_SHIFT) x (IN_HEIGHT>>SCALE_SHIFT).
- ADDR_WIDTH, 17, BRAM address width. Must hold W*H-1, where W = IN_WIDTH>>SCALE_SHIFT and H = IN_HEIGHT>>SCALE_SHIFT.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous reset, active-low.
- clear_in  input  1  single-cycle request to clear the frame buffer.
- pixel_valid_in  input  1  camera pixel valid.
- hcount_in  input  11  camera x of the current pixel.
- vcount_in  input  10  camera y of the current pixel.
- pixel_in  input  16  RGB565 camera pixel.
- thresh_in  input  1  pixel passed colour threshold; aligned with pixel_valid_in.
- draw_in  input  1  pixel is part of a drawn stroke; aligned with pixel_valid_in.
- draw_color_in  input  2  stroke colour index: 00 yellow, 01 magenta, 10 green, 11 red.
- cross_x_in  input  11  crosshair x in camera coordinates.
- cross_y_in  input  10  crosshair y in camera coordinates.
- bram_addr_out  output  ADDR_WIDTH  write address.
- bram_data_out  output  8  tagged pixel.
- bram_we_out  output  1  write enable.
- busy_out  output  1  high while a clear sweep runs.

Behaviour:
- Reset (rst_in low at a clock edge): all outputs 0, FSM to IDLE, pipeline valid bits cleared. Reset mid-clear aborts the sweep with no further writes.
- Keep rule: a pixel is kept iff
  - pixel_valid_in = 1,
  - hcount_in < IN_WIDTH and vcount_in < IN_HEIGHT,
  - the low SCALE_SHIFT bits of hcount_in and of vcount_in are all zero,
  - FSM is IDLE.
  All other pixels produce no write.
- Address: sx = hcount_in>>SCALE_SHIFT, sy = vcount_in>>SCALE_SHIFT, addr = sy*W + sx, computed to full width without truncation.
- Luma:
  - R = pixel_in[15:11], G = pixel_in[10:5], B = pixel_in[4:0].
  - sum8 = 2R + 2G + 2B (max 250, unsigned 8 bits).
  - gray6 = sum8[7:2].
- Tag priority (first match wins):
  - draw_in: data = {2'b11, 4'b0000, draw_color_in}.
  - thresh_in: data = {2'b10, gray6}.
  - crosshair, i.e. sx == cross_x_in>>SCALE_SHIFT or sy == cross_y_in>>SCALE_SHIFT: data = {2'b01, gray6}.
  - otherwise: data = {2'b00, gray6}.
- Pipeline: 2 stages, fully pipelined, one pixel per cycle.
  - Stage 1 registers the inputs and computes the keep flag, addr and sum8.
  - Stage 2 registers tag, data and address.
  - A pixel kept at edge N appears on bram_we_out/bram_addr_out/bram_data_out after edge N+2.
  - bram_we_out is high for exactly one cycle per kept pixel. addr/data are don't-care when we is low.
- FSM IDLE -> CLEAR:
  - Taken when clear_in = 1 in IDLE.
  - Both pipeline valid bits are cleared on entry, so in-flight camera pixels are dropped.
  - busy_out rises the cycle after clear_in is sampled.
- FSM CLEAR behaviour:
  - Counter starts at 0.
  - Each cycle drives bram_we_out = 1, bram_addr_out = counter, bram_data_out = 8'h00.
  - After address W*H-1 the FSM returns to IDLE and busy_out falls the same edge.
  - The sweep is exactly W*H write cycles.
  - clear_in during CLEAR is ignored (no restart). Camera pixels during CLEAR are dropped.
- Simultaneous clear_in and kept pixel in IDLE: clear wins and the pixel is dropped.
- First camera pixel accepted after CLEAR: sampled in IDLE, so its write occurs no earlier than 2 cycles after busy_out falls.

Test Plan:
- Reset, then pixel h=10, v=4, pixel_in=16'hFFFF, no flags -> 2 cycles later a single write: addr 325, data 8'h3E.
- Same stream with h=11 or v=5, and separately h=320 -> no write.
- pixel_in=16'h0000, thresh_in=1 -> data 8'h80. Add draw_in=1 with color 2'b10 -> 8'hC2 (draw beats threshold).
- cross_x_in=20, cross_y_in=100, pixel h=20, v=4, pixel_in=16'h0000 -> addr 330, data 8'h40. Same pixel with h=22, v=4 -> data 8'h00.
- clear_in pulse with kept pixels arriving every cycle:
  - busy_out high for 19200 cycles.
  - addresses 0..19199 written in order, all data 8'h00.
  - no camera writes until busy_out falls.
  - a second clear_in mid-sweep has no effect.
- rst_in low at clear address 500 -> no writes the next cycle, busy_out=0. Normal pixel writing resumes after rst_in returns high.

Source files
------------

// File: rtl/tag_pixel_writer.sv
// Encoder for the 8-bit tagged frame-buffer format: decimates the RGB565 camera
// stream, tags each kept pixel and writes it to BRAM; also runs a full-buffer clear sweep.
module tag_pixel_writer #(
    parameter int IN_WIDTH    = 320,
    parameter int IN_HEIGHT   = 240,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_WIDTH  = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  clear_in,
    input  logic                  pixel_valid_in,
    input  logic [10:0]           hcount_in,
    input  logic [9:0]            vcount_in,
    input  logic [15:0]           pixel_in,
    input  logic                  thresh_in,
    input  logic                  draw_in,
    input  logic [1:0]            draw_color_in,
    input  logic [10:0]           cross_x_in,
    input  logic [9:0]            cross_y_in,
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    output logic [7:0]            bram_data_out,
    output logic                  bram_we_out,
    output logic                  busy_out
);

    localparam int FB_W = IN_WIDTH >> SCALE_SHIFT;
    localparam int FB_H = IN_HEIGHT >> SCALE_SHIFT;
    localparam logic [ADDR_WIDTH-1:0] FB_W_A    = ADDR_WIDTH'(FB_W);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_W * FB_H - 1);
    localparam logic [10:0] H_MASK = 11'((1 << SCALE_SHIFT) - 1);
    localparam logic [9:0]  V_MASK = 10'((1 << SCALE_SHIFT) - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    // Luma approximation: (2R + 2G + 2B) >> 2, fits in 6 bits.
    function automatic logic [5:0] luma_gray6(input logic [15:0] px);
        logic [7:0] sum8;
        sum8 = ({3'b000, px[15:11]} + {2'b00, px[10:5]} + {3'b000, px[4:0]}) << 1;
        return 6'(sum8 >> 2);
    endfunction

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;

    logic                  r1_valid;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic [5:0]            r1_gray;
    logic                  r1_draw;
    logic                  r1_thresh;
    logic [1:0]            r1_color;
    logic                  r1_cross;

    logic                  r2_valid;
    logic [ADDR_WIDTH-1:0] r2_addr;
    logic [7:0]            r2_data;

    logic [10:0]           w_sx;
    logic [9:0]            w_sy;
    logic                  w_clear_start;
    logic                  w_keep;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_tag_data;

    assign w_sx          = hcount_in >> SCALE_SHIFT;
    assign w_sy          = vcount_in >> SCALE_SHIFT;
    assign w_clear_start = (r_state == ST_IDLE) && clear_in;
    assign w_addr        = ADDR_WIDTH'(w_sy) * FB_W_A + ADDR_WIDTH'(w_sx);

    // Keep decision; a clear request in the same cycle drops the pixel.
    always_comb begin
        w_keep = 1'b0;
        if (pixel_valid_in && (r_state == ST_IDLE) && !clear_in &&
            (hcount_in < 11'(IN_WIDTH)) && (vcount_in < 10'(IN_HEIGHT)) &&
            ((hcount_in & H_MASK) == 11'd0) && ((vcount_in & V_MASK) == 10'd0)) begin
            w_keep = 1'b1;
        end else begin
            w_keep = 1'b0;
        end
    end

    // Tag priority: draw, threshold, crosshair, plain gray.
    always_comb begin
        w_tag_data = 8'h00;
        if (r1_draw) begin
            w_tag_data = {2'b11, 4'b0000, r1_color};
        end else if (r1_thresh) begin
            w_tag_data = {2'b10, r1_gray};
        end else if (r1_cross) begin
            w_tag_data = {2'b01, r1_gray};
        end else begin
            w_tag_data = {2'b00, r1_gray};
        end
    end

    // Stage 1: capture keep flag, address, luma and tag inputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r1_valid  <= 1'b0;
            r1_addr   <= '0;
            r1_gray   <= 6'd0;
            r1_draw   <= 1'b0;
            r1_thresh <= 1'b0;
            r1_color  <= 2'b00;
            r1_cross  <= 1'b0;
        end else begin
            r1_valid  <= w_keep;
            r1_addr   <= w_addr;
            r1_gray   <= luma_gray6(pixel_in);
            r1_draw   <= draw_in;
            r1_thresh <= thresh_in;
            r1_color  <= draw_color_in;
            r1_cross  <= (w_sx == (cross_x_in >> SCALE_SHIFT)) ||
                         (w_sy == (cross_y_in >> SCALE_SHIFT));
        end
    end

    // Stage 2: tagged data and address; flushed when a clear begins.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r2_valid <= 1'b0;
            r2_addr  <= '0;
            r2_data  <= 8'h00;
        end else begin
            r2_valid <= r1_valid && !w_clear_start;
            r2_addr  <= r1_addr;
            r2_data  <= w_tag_data;
        end
    end

    // Control FSM and registered BRAM port; the first clear write issues on entry
    // so busy_out is high exactly during the clear write cycles.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state       <= ST_IDLE;
            r_clr_cnt     <= '0;
            busy_out      <= 1'b0;
            bram_we_out   <= 1'b0;
            bram_addr_out <= '0;
            bram_data_out <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_in) begin
                        r_state       <= ST_CLEAR;
                        r_clr_cnt     <= '0;
                        busy_out      <= 1'b1;
                        bram_we_out   <= 1'b1;
                        bram_addr_out <= '0;
                        bram_data_out <= 8'h00;
                    end else begin
                        busy_out      <= 1'b0;
                        bram_we_out   <= r2_valid;
                        bram_addr_out <= r2_addr;
                        bram_data_out <= r2_data;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == LAST_ADDR) begin
                        r_state       <= ST_IDLE;
                        busy_out      <= 1'b0;
                        bram_we_out   <= 1'b0;
                        bram_addr_out <= '0;
                        bram_data_out <= 8'h00;
                    end else begin
                        r_clr_cnt     <= r_clr_cnt + 1'b1;
                        busy_out      <= 1'b1;
                        bram_we_out   <= 1'b1;
                        bram_addr_out <= r_clr_cnt + 1'b1;
                        bram_data_out <= 8'h00;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    busy_out      <= 1'b0;
                    bram_we_out   <= 1'b0;
                    bram_addr_out <= '0;
                    bram_data_out <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tag_pixel_writer.sv
// Directed table-driven bench for tag_pixel_writer plus clear-sweep and reset sequences.
module tb_tag_pixel_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        pv;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic [15:0] pix;
    logic        thr;
    logic        drw;
    logic [1:0]  col;
    logic [10:0] cx;
    logic [9:0]  cy;
    logic [16:0] addr;
    logic [7:0]  data;
    logic        we;
    logic        busy;

    int tests = 0;
    int fails = 0;

    tag_pixel_writer #(
        .IN_WIDTH(320), .IN_HEIGHT(240), .SCALE_SHIFT(1), .ADDR_WIDTH(17)
    ) dut (
        .clk_in(clk), .rst_in(rst_n), .clear_in(clear), .pixel_valid_in(pv),
        .hcount_in(hc), .vcount_in(vc), .pixel_in(pix), .thresh_in(thr),
        .draw_in(drw), .draw_color_in(col), .cross_x_in(cx), .cross_y_in(cy),
        .bram_addr_out(addr), .bram_data_out(data), .bram_we_out(we), .busy_out(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] h;
        logic [9:0]  v;
        logic [15:0] p;
        logic        t;
        logic        d;
        logic [1:0]  c;
        logic [10:0] x;
        logic [9:0]  y;
        logic        e_we;
        logic [16:0] e_addr;
        logic [7:0]  e_data;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    initial begin
        int          busy_cycles;
        int          clr_errs;
        int          first_bad;
        logic [16:0] exp_a;
        logic        found;

        vecs[0]  = '{11'd10,  10'd4,   16'hFFFF, 1'b0, 1'b0, 2'b00, 11'd1000, 10'd1000, 1'b1, 17'd325,   8'h3E};
        vecs[1]  = '{11'd11,  10'd4,   16'hFFFF, 1'b0, 1'b0, 2'b00, 11'd1000, 10'd1000, 1'b0, 17'd0,     8'h00};
        vecs[2]  = '{11'd10,  10'd5,   16'hFFFF, 1'b0, 1'b0, 2'b00, 11'd1000, 10'd1000, 1'b0, 17'd0,     8'h00};
        vecs[3]  = '{11'd320, 10'd4,   16'hFFFF, 1'b0, 1'b0, 2'b00, 11'd1000, 10'd1000, 1'b0, 17'd0,     8'h00};
        vecs[4]  = '{11'd10,  10'd240, 16'hFFFF, 1'b0, 1'b0, 2'b00, 11'd1000, 10'd1000, 1'b0, 17'd0,     8'h00};
        vecs[5]  = '{11'd10,  10'd4,   16'h0000, 1'b1, 1'b0, 2'b00, 11'd1000, 10'd1000, 1'b1, 17'd325,   8'h80};
        vecs[6]  = '{11'd10,  10'd4,   16'h0000, 1'b1, 1'b1, 2'b10, 11'd1000, 10'd1000, 1'b1, 17'd325,   8'hC2};
        vecs[7]  = '{11'd20,  10'd4,   16'h0000, 1'b0, 1'b0, 2'b00, 11'd20,   10'd100,  1'b1, 17'd330,   8'h40};
        vecs[8]  = '{11'd22,  10'd4,   16'h0000, 1'b0, 1'b0, 2'b00, 11'd20,   10'd100,  1'b1, 17'd331,   8'h00};
        vecs[9]  = '{11'd0,   10'd8,   16'hF800, 1'b0, 1'b0, 2'b00, 11'd1000, 10'd8,    1'b1, 17'd640,   8'h4F};
        vecs[10] = '{11'd318, 10'd238, 16'h07E0, 1'b0, 1'b0, 2'b00, 11'd1000, 10'd1000, 1'b1, 17'd19199, 8'h1F};
        vecs[11] = '{11'd0,   10'd0,   16'h1234, 1'b1, 1'b1, 2'b11, 11'd1000, 10'd1000, 1'b1, 17'd0,     8'hC3};
        vecs[12] = '{11'd2,   10'd0,   16'hFFFF, 1'b0, 1'b1, 2'b00, 11'd1000, 10'd1000, 1'b1, 17'd1,     8'hC0};
        vecs[13] = '{11'd4,   10'd2,   16'h001F, 1'b1, 1'b0, 2'b00, 11'd1000, 10'd1000, 1'b1, 17'd162,   8'h8F};

        rst_n = 1'b0; clear = 1'b0; pv = 1'b0; hc = 11'd0; vc = 10'd0; pix = 16'h0000;
        thr = 1'b0; drw = 1'b0; col = 2'b00; cx = 11'd1000; cy = 10'd1000;
        repeat (3) @(negedge clk);
        check("reset_we", 32'(we), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_addr", 32'(addr), 32'd0);
        check("reset_data", 32'(data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            hc = vecs[i].h; vc = vecs[i].v; pix = vecs[i].p; thr = vecs[i].t;
            drw = vecs[i].d; col = vecs[i].c; cx = vecs[i].x; cy = vecs[i].y; pv = 1'b1;
            @(negedge clk);
            pv = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_early", i), 32'(we), 32'd0);
            @(negedge clk);
            check($sformatf("vec%0d_we", i), 32'(we), 32'(vecs[i].e_we));
            if (vecs[i].e_we) begin
                check($sformatf("vec%0d_addr", i), 32'(addr), 32'(vecs[i].e_addr));
                check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].e_data));
            end
            @(negedge clk);
            check($sformatf("vec%0d_single", i), 32'(we), 32'd0);
        end

        // Back-to-back pixels: one write per cycle.
        thr = 1'b0; drw = 1'b0; cx = 11'd1000; cy = 10'd1000; pix = 16'hFFFF; vc = 10'd0;
        for (int i = 0; i < 3; i++) begin
            hc = 11'(2 * i); pv = 1'b1;
            @(negedge clk);
        end
        pv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("burst%0d_we", i), 32'(we), 32'd1);
            check($sformatf("burst%0d_addr", i), 32'(addr), i);
            @(negedge clk);
        end
        check("burst_end_we", 32'(we), 32'd0);

        // Clear sweep with a kept pixel on every cycle, clear repeated mid-sweep.
        hc = 11'd0; vc = 10'd0; pix = 16'hFFFF; pv = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_clear_data", 32'(data), 32'h3E);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        busy_cycles = 0; clr_errs = 0; first_bad = -1; exp_a = 17'd0;
        for (int i = 0; i < 20000; i++) begin
            if (!busy) break;
            busy_cycles++;
            if (!(we === 1'b1 && addr === exp_a && data === 8'h00)) begin
                clr_errs++;
                if (first_bad < 0) first_bad = i;
            end
            exp_a = exp_a + 17'd1;
            clear = (i == 1000) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        clear = 1'b0;
        check("clear_busy_cycles", busy_cycles, 32'd19200);
        if (clr_errs != 0) $display("FAIL clear_sweep: first bad write at cycle %0d", first_bad);
        check("clear_sweep_errs", clr_errs, 32'd0);
        check("post_clear_we0", 32'(we), 32'd0);
        @(negedge clk);
        check("post_clear_we1", 32'(we), 32'd0);
        @(negedge clk);
        check("post_clear_we2", 32'(we), 32'd0);
        @(negedge clk);
        check("resume_we", 32'(we), 32'd1);
        check("resume_addr", 32'(addr), 32'd0);
        check("resume_data", 32'(data), 32'h3E);

        // Reset in the middle of a sweep.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (busy && addr == 17'd500) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_addr500", 32'(found), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midclr_rst_we", 32'(we), 32'd0);
        check("midclr_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_we1", 32'(we), 32'd0);
        @(negedge clk);
        check("after_rst_we2", 32'(we), 32'd0);
        @(negedge clk);
        check("after_rst_we", 32'(we), 32'd1);
        check("after_rst_addr", 32'(addr), 32'd0);
        check("after_rst_data", 32'(data), 32'h3E);
        check("after_rst_busy", 32'(busy), 32'd0);
        pv = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
